// File: rtl/outport_alloc.sv
// rtl/outport_alloc.sv - per-output-port VC and switch allocator for a NoC router
module outport_alloc #(
    parameter int NPORT  = 5,
    parameter int NVC    = 2,
    parameter int PORT_W = (NPORT > 1) ? $clog2(NPORT) : 1,
    parameter int VC_W   = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORT-1:0]      req_i,
    input  logic [NPORT*VC_W-1:0] vch_i,
    input  logic [NPORT*2-1:0]    type_i,
    input  logic [NVC-1:0]        rdy_i,
    input  logic [NVC-1:0]        lck_i,
    output logic [NPORT-1:0]      gnt_o,
    output logic                  sel_vld_o,
    output logic [PORT_W-1:0]     sel_o,
    output logic [VC_W-1:0]       sel_vch_o,
    output logic [NVC-1:0]        own_vld_o,
    output logic [NVC*PORT_W-1:0] own_o
);

    localparam logic [1:0] FT_HEAD   = 2'b00;
    localparam logic [1:0] FT_SINGLE = 2'b11;
    localparam int         RR_W      = (NPORT > NVC) ? NPORT : NVC;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    vc_state_e         state_q [NVC];
    vc_state_e         state_d [NVC];
    logic [PORT_W-1:0] own_q   [NVC];
    logic [PORT_W-1:0] own_d   [NVC];
    logic [PORT_W-1:0] vptr_q  [NVC];
    logic [PORT_W-1:0] vptr_d  [NVC];
    logic [VC_W-1:0]   sptr_q;
    logic [VC_W-1:0]   sptr_d;

    logic [VC_W-1:0]   vch     [NPORT];
    logic [1:0]        ftype   [NPORT];
    logic [NPORT-1:0]  is_head;
    logic [NPORT-1:0]  owns;
    logic [NPORT-1:0]  cand    [NVC];
    logic [NVC-1:0]    alloc_vld;
    logic [PORT_W-1:0] alloc_win [NVC];
    logic [NVC-1:0]    elig;
    logic              pick_vld;
    logic [VC_W-1:0]   pick_vc;
    logic [PORT_W-1:0] pick_port;
    logic              pick_tail;

    // First set bit of mask at or after ptr, wrapping modulo n; -1 when empty.
    function automatic int rr_first(input logic [RR_W-1:0] mask, input int ptr, input int n);
        int res;
        int idx;
        res = -1;
        idx = 0;
        for (int i = 0; i < RR_W; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            for (int p = 0; p < RR_W; p++) begin
                if (res < 0 && i < n && p == idx && mask[p]) res = p;
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            vch[p]     = vch_i[p*VC_W +: VC_W];
            ftype[p]   = type_i[p*2 +: 2];
            is_head[p] = (ftype[p] == FT_HEAD) || (ftype[p] == FT_SINGLE);
        end
    end

    always_comb begin
        owns = '0;
        for (int v = 0; v < NVC; v++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (state_q[v] == VC_BUSY && own_q[v] == PORT_W'(p)) owns[p] = 1'b1;
            end
        end
    end

    // An input holding a VC may not bid for another until its tail has left.
    always_comb begin
        int w;
        w = 0;
        for (int v = 0; v < NVC; v++) begin
            cand[v]      = '0;
            alloc_vld[v] = 1'b0;
            alloc_win[v] = '0;
            for (int p = 0; p < NPORT; p++) begin
                cand[v][p] = req_i[p] && (vch[p] == VC_W'(v)) && is_head[p] && !owns[p];
            end
            if (state_q[v] == VC_IDLE && rdy_i[v] && !lck_i[v]) begin
                w = rr_first(RR_W'(cand[v]), int'(vptr_q[v]), NPORT);
                if (w >= 0) begin
                    alloc_vld[v] = 1'b1;
                    alloc_win[v] = PORT_W'(w);
                end
            end
        end
    end

    always_comb begin
        int sp;
        elig      = '0;
        pick_vld  = 1'b0;
        pick_vc   = '0;
        pick_port = '0;
        pick_tail = 1'b0;
        for (int v = 0; v < NVC; v++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (state_q[v] == VC_BUSY && own_q[v] == PORT_W'(p) &&
                    req_i[p] && vch[p] == VC_W'(v)) elig[v] = 1'b1;
            end
        end
        sp = rr_first(RR_W'(elig), int'(sptr_q), NVC);
        if (sp >= 0) begin
            pick_vld = 1'b1;
            pick_vc  = VC_W'(sp);
            for (int v = 0; v < NVC; v++) begin
                if (v == sp) pick_port = own_q[v];
            end
            for (int p = 0; p < NPORT; p++) begin
                if (pick_port == PORT_W'(p)) pick_tail = ftype[p][1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= VC_IDLE;
                own_q[v]   <= '0;
                vptr_q[v]  <= '0;
            end
            sptr_q <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= state_d[v];
                own_q[v]   <= own_d[v];
                vptr_q[v]  <= vptr_d[v];
            end
            sptr_q <= sptr_d;
        end
    end

    // Allocation only fires on IDLE VCs and release only on BUSY ones, so they never collide.
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            state_d[v] = state_q[v];
            own_d[v]   = own_q[v];
            vptr_d[v]  = vptr_q[v];
            if (alloc_vld[v]) begin
                state_d[v] = VC_BUSY;
                own_d[v]   = alloc_win[v];
                vptr_d[v]  = (int'(alloc_win[v]) == NPORT - 1) ? '0 : alloc_win[v] + 1'b1;
            end else if (pick_vld && pick_vc == VC_W'(v) && pick_tail) begin
                state_d[v] = VC_IDLE;
            end
        end
        sptr_d = sptr_q;
        if (pick_vld) sptr_d = (int'(pick_vc) == NVC - 1) ? '0 : pick_vc + 1'b1;
    end

    always_comb begin
        gnt_o     = '0;
        sel_vld_o = pick_vld;
        sel_o     = pick_port;
        sel_vch_o = pick_vc;
        for (int p = 0; p < NPORT; p++) begin
            if (pick_vld && pick_port == PORT_W'(p)) gnt_o[p] = 1'b1;
        end
        for (int v = 0; v < NVC; v++) begin
            own_vld_o[v]                = (state_q[v] == VC_BUSY);
            own_o[v*PORT_W +: PORT_W]   = (state_q[v] == VC_BUSY) ? own_q[v] : '0;
        end
    end

endmodule

// File: tb/tb_outport_alloc.sv
// tb/tb_outport_alloc.sv - directed and randomized bench for outport_alloc
module tb_outport_alloc;
    localparam int NPORT  = 5;
    localparam int NVC    = 2;
    localparam int PORT_W = 3;
    localparam int VC_W   = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NPORT-1:0]      req_i;
    logic [NPORT*VC_W-1:0] vch_i;
    logic [NPORT*2-1:0]    type_i;
    logic [NVC-1:0]        rdy_i;
    logic [NVC-1:0]        lck_i;
    logic [NPORT-1:0]      gnt_o;
    logic                  sel_vld_o;
    logic [PORT_W-1:0]     sel_o;
    logic [VC_W-1:0]       sel_vch_o;
    logic [NVC-1:0]        own_vld_o;
    logic [NVC*PORT_W-1:0] own_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    outport_alloc #(.NPORT(NPORT), .NVC(NVC)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .vch_i(vch_i), .type_i(type_i),
        .rdy_i(rdy_i), .lck_i(lck_i), .gnt_o(gnt_o), .sel_vld_o(sel_vld_o),
        .sel_o(sel_o), .sel_vch_o(sel_vch_o), .own_vld_o(own_vld_o), .own_o(own_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: VC ownership table plus round-robin pointers.
    bit m_busy [NVC];
    int m_own  [NVC];
    int m_vptr [NVC];
    int m_sptr;

    function automatic int vc_of(input int p);
        return int'(vch_i[p*VC_W +: VC_W]);
    endfunction

    function automatic int ty_of(input int p);
        return int'(type_i[p*2 +: 2]);
    endfunction

    function automatic bit owns_any(input int p);
        for (int v = 0; v < NVC; v++) if (m_busy[v] && m_own[v] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_alloc(input int v);
        int best = -1;
        int bestd = NPORT;
        int d;
        if (m_busy[v] || !rdy_i[v] || lck_i[v]) return -1;
        for (int p = 0; p < NPORT; p++) begin
            if (req_i[p] && vc_of(p) == v && (ty_of(p) == 0 || ty_of(p) == 3) && !owns_any(p)) begin
                d = (p - m_vptr[v] + NPORT) % NPORT;
                if (d < bestd) begin bestd = d; best = p; end
            end
        end
        return best;
    endfunction

    function automatic int m_pick();
        int best = -1;
        int bestd = NVC;
        int d;
        for (int v = 0; v < NVC; v++) begin
            if (m_busy[v] && req_i[m_own[v]] && vc_of(m_own[v]) == v) begin
                d = (v - m_sptr + NVC) % NVC;
                if (d < bestd) begin bestd = d; best = v; end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NVC; v++) begin
                m_busy[v] <= 1'b0;
                m_own[v]  <= 0;
                m_vptr[v] <= 0;
            end
            m_sptr <= 0;
        end else begin : upd
            int w;
            int pk;
            for (int v = 0; v < NVC; v++) begin
                w = m_alloc(v);
                if (w >= 0) begin
                    m_busy[v] <= 1'b1;
                    m_own[v]  <= w;
                    m_vptr[v] <= (w + 1) % NPORT;
                end
            end
            pk = m_pick();
            if (pk >= 0) begin
                m_sptr <= (pk + 1) % NVC;
                if (ty_of(m_own[pk]) >= 2) m_busy[pk] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int pk;
        if (!rst_n) begin
            chk("rst_gnt", int'(gnt_o), 0);
            chk("rst_sel_vld", int'(sel_vld_o), 0);
            chk("rst_own_vld", int'(own_vld_o), 0);
            chk("rst_own", int'(own_o), 0);
        end else begin
            pk = m_pick();
            chk("gnt", int'(gnt_o), (pk >= 0) ? (1 << m_own[pk]) : 0);
            chk("sel_vld", int'(sel_vld_o), (pk >= 0) ? 1 : 0);
            chk("sel", int'(sel_o), (pk >= 0) ? m_own[pk] : 0);
            chk("sel_vch", int'(sel_vch_o), (pk >= 0) ? pk : 0);
            for (int v = 0; v < NVC; v++) begin
                chk("own_vld", int'(own_vld_o[v]), int'(m_busy[v]));
                if (m_busy[v]) chk("own", int'(own_o[v*PORT_W +: PORT_W]), m_own[v]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i  = '0;
        vch_i  = '0;
        type_i = '0;
        rdy_i  = '1;
        lck_i  = '0;
    endtask

    task automatic flit(input int p, input int v, input int t);
        req_i[p]        = 1'b1;
        vch_i[p]        = v[0];
        type_i[p*2 +: 2] = t[1:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic gate_test(input bit use_rdy);
        if (use_rdy) rdy_i = 2'b10; else lck_i = 2'b01;
        flit(0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("gate_hold_vld", int'(own_vld_o[0]), 0);
            chk("gate_hold_gnt", int'(gnt_o), 0);
            cyc();
        end
        rdy_i = 2'b11;
        lck_i = 2'b00;
        #1; chk("gate_open_vld", int'(own_vld_o[0]), 0);
        cyc();
        #1; chk("gate_alloc_vld", int'(own_vld_o[0]), 1); chk("gate_gnt", int'(gnt_o), 1);
        cyc();
        idle_inputs();
        #1; chk("gate_release", int'(own_vld_o), 0);
        cyc();
    endtask

    initial begin : drv
        int rem [NPORT];
        int len [NPORT];
        int idx [NPORT];
        int gvc [NPORT];
        bit pres [NPORT];
        logic [NPORT-1:0] g;
        int t;

        // single packet on VC1 from input 2
        do_reset();
        flit(2, 1, 0); #1; chk("t1_c0_gnt", int'(gnt_o), 0); cyc();
        #1;
        chk("t1_own_vld", int'(own_vld_o), 2);
        chk("t1_own1", int'(own_o[5:3]), 2);
        chk("t1_c1_gnt", int'(gnt_o), 5'b00100);
        chk("t1_c1_vch", int'(sel_vch_o), 1);
        cyc();
        flit(2, 1, 1); #1; chk("t1_c2_gnt", int'(gnt_o), 5'b00100); cyc();
        flit(2, 1, 2); #1; chk("t1_c3_gnt", int'(gnt_o), 5'b00100); chk("t1_c3_vch", int'(sel_vch_o), 1); cyc();
        idle_inputs(); #1;
        chk("t1_idle", int'(own_vld_o), 0);
        chk("t1_model_vptr", m_vptr[1], 3);
        cyc();

        // contention on VC0 between inputs 0 and 3
        do_reset();
        flit(0, 0, 0); flit(3, 0, 0); #1; chk("t2_c0_gnt", int'(gnt_o), 0); cyc();
        #1; chk("t2_own_vld", int'(own_vld_o), 1); chk("t2_own0", int'(own_o[2:0]), 0); chk("t2_c1_gnt", int'(gnt_o), 1); cyc();
        flit(0, 0, 2); #1; chk("t2_c2_gnt", int'(gnt_o), 1); cyc();
        req_i[0] = 1'b0; #1; chk("t2_c3_gnt", int'(gnt_o), 0); chk("t2_c3_vld", int'(own_vld_o), 0); cyc();
        #1; chk("t2_own3", int'(own_o[2:0]), 3); chk("t2_c4_gnt", int'(gnt_o), 5'b01000); chk("t2_model_vptr", m_vptr[0], 4); cyc();
        flit(3, 0, 2); #1; chk("t2_c5_gnt", int'(gnt_o), 5'b01000); cyc();
        idle_inputs(); #1; chk("t2_idle", int'(own_vld_o), 0); cyc();

        // two VCs interleave
        do_reset();
        flit(1, 0, 0); flit(4, 1, 0); #1; chk("t3_c0_gnt", int'(gnt_o), 0); cyc();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_vch", int'(sel_vch_o), k % 2);
            chk("t3_gnt", int'(gnt_o), (k % 2 == 1) ? 5'b10000 : 5'b00010);
            cyc();
            if (k % 2 == 1) type_i[9:8] = 2'b01; else type_i[3:2] = 2'b01;
        end

        // lock gating, then ready gating
        do_reset();
        gate_test(1'b0);
        gate_test(1'b1);

        // single-flit packets back to back on VC1
        do_reset();
        flit(0, 1, 3); flit(2, 1, 3); #1; chk("t5_c0_gnt", int'(gnt_o), 0); cyc();
        #1; chk("t5_own", int'(own_o[5:3]), 0); chk("t5_vld", int'(own_vld_o), 2); chk("t5_c1_gnt", int'(gnt_o), 1); cyc();
        req_i[0] = 1'b0; #1; chk("t5_c2_vld", int'(own_vld_o), 0); chk("t5_c2_gnt", int'(gnt_o), 0); cyc();
        #1; chk("t5_c3_vld", int'(own_vld_o), 2); chk("t5_c3_own", int'(own_o[5:3]), 2); chk("t5_c3_gnt", int'(gnt_o), 5'b00100); cyc();
        idle_inputs(); #1; chk("t5_idle", int'(own_vld_o), 0); cyc();

        // reset in the middle of a packet
        do_reset();
        flit(2, 1, 0); #1; cyc();
        #1; chk("t6_head_gnt", int'(gnt_o), 5'b00100); cyc();
        flit(2, 1, 1); #1; chk("t6_body_gnt", int'(gnt_o), 5'b00100); cyc();
        flit(2, 1, 2); #1; chk("t6_tail_pending", int'(gnt_o), 5'b00100);
        rst_n = 1'b0; #1;
        chk("t6_rst_gnt", int'(gnt_o), 0);
        chk("t6_rst_vld", int'(own_vld_o), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; chk("t6_stale_gnt", int'(gnt_o), 0); chk("t6_stale_vld", int'(own_vld_o), 0); cyc();
        end
        flit(2, 1, 0); #1; chk("t6_fresh_c0", int'(gnt_o), 0); cyc();
        #1; chk("t6_fresh_c1", int'(gnt_o), 5'b00100); cyc();

        // randomized traffic
        do_reset();
        for (int p = 0; p < NPORT; p++) begin
            rem[p] = 0; len[p] = 0; idx[p] = 0; gvc[p] = 0; pres[p] = 1'b0;
        end
        g = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (g[p] && rem[p] > 0) begin
                    idx[p]++;
                    rem[p]--;
                    pres[p] = 1'b0;
                end
                if (rem[p] == 0 && $urandom_range(0, 2) == 0) begin
                    len[p] = $urandom_range(1, 4);
                    rem[p] = len[p];
                    idx[p] = 0;
                    gvc[p] = $urandom_range(0, 1);
                end
                if (rem[p] > 0) begin
                    if (!pres[p]) pres[p] = ($urandom_range(0, 3) != 0);
                    t = (len[p] == 1) ? 3 : (idx[p] == 0) ? 0 : (rem[p] == 1) ? 2 : 1;
                    if (pres[p]) flit(p, gvc[p], t); else req_i[p] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    flit(p, $urandom_range(0, 1), $urandom_range(1, 2));
                end else begin
                    req_i[p] = 1'b0;
                end
            end
            for (int v = 0; v < NVC; v++) begin
                rdy_i[v] = ($urandom_range(0, 3) != 0);
                lck_i[v] = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            g = gnt_o;
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
